// File: rtl/mca_pkg.sv
// Shared definitions for the multichannel-analyser histogram engine:
// one-hot state encodings, command event bit positions and the
// saturating increment used by every counter in the block.
package mca_pkg;

  // One-hot state encodings
  localparam logic [4:0] ST_PAUSE_OH = 5'b00001;
  localparam logic [4:0] ST_IDLE_OH  = 5'b00010;
  localparam logic [4:0] ST_READ_OH  = 5'b00100;
  localparam logic [4:0] ST_WRITE_OH = 5'b01000;
  localparam logic [4:0] ST_CLEAR_OH = 5'b10000;

  typedef enum logic [4:0] {
    ST_PAUSE = ST_PAUSE_OH,
    ST_IDLE  = ST_IDLE_OH,
    ST_READ  = ST_READ_OH,
    ST_WRITE = ST_WRITE_OH,
    ST_CLEAR = ST_CLEAR_OH
  } state_t;

  // Command event vector layout; lower index = higher priority
  localparam int CMD_W     = 3;
  localparam int CMD_CLEAR = 0;
  localparam int CMD_PAUSE = 1;
  localparam int CMD_START = 2;

  // Widest counter the saturating helper supports
  localparam int SAT_W = 64;

  // Increment value, holding at the all-ones value of a width-bit counter
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                               input int width);
    logic [SAT_W-1:0] max_v;
    if (width >= SAT_W) begin
      max_v = {SAT_W{1'b1}};
    end else begin
      max_v = (SAT_W'(1) << width) - SAT_W'(1);
    end
    if (value >= max_v) begin
      sat_inc = max_v;
    end else begin
      sat_inc = value + SAT_W'(1);
    end
  endfunction

endpackage

// File: rtl/mca_cmd_sync.sv
// Rising-edge detector and priority encoder for the three level commands.
// The first clock after reset only primes the history registers, so a
// command held high through reset never produces an event.
module mca_cmd_sync
  import mca_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_start,
  input  logic             cmd_pause,
  input  logic             cmd_clear,
  output logic [CMD_W-1:0] cmd_event
);

  logic             armed;
  logic [CMD_W-1:0] cmd_prev;
  logic [CMD_W-1:0] cmd_raw;
  logic [CMD_W-1:0] cmd_edge;

  // Gather commands into the priority-ordered vector and find rising edges
  always_comb begin
    cmd_raw            = '0;
    cmd_raw[CMD_CLEAR] = cmd_clear;
    cmd_raw[CMD_PAUSE] = cmd_pause;
    cmd_raw[CMD_START] = cmd_start;
    cmd_edge           = cmd_raw & ~cmd_prev & {CMD_W{armed}};
  end

  // Command history and arming flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed    <= 1'b0;
      cmd_prev <= '0;
    end else begin
      armed    <= 1'b1;
      cmd_prev <= cmd_raw;
    end
  end

  // Keep only the highest-priority edge: clear > pause > start
  always_comb begin
    cmd_event = '0;
    if (cmd_edge[CMD_CLEAR]) begin
      cmd_event[CMD_CLEAR] = 1'b1;
    end else if (cmd_edge[CMD_PAUSE]) begin
      cmd_event[CMD_PAUSE] = 1'b1;
    end else if (cmd_edge[CMD_START]) begin
      cmd_event[CMD_START] = 1'b1;
    end else begin
      cmd_event = '0;
    end
  end

endmodule

// File: rtl/mca_histogram.sv
// Multichannel-analyser histogram engine. Each accepted pulse height is
// binned into a channel of an external single-port synchronous count RAM
// with a read-modify-write (IDLE -> READ -> WRITE). Counts saturate, a
// preset total can stop acquisition, pulses arriving during the RMW are
// counted as dead-time losses and CLEAR sweeps the whole RAM to zero.
module mca_histogram
  import mca_pkg::*;
#(
  parameter int ADC_W  = 14,
  parameter int ADDR_W = 10,  // must not exceed ADC_W
  parameter int CNT_W  = 32   // at most SAT_W
) (
  input  logic              CLOCK_65,
  input  logic              rst_n,
  input  logic [ADC_W-1:0]  pulse_height,
  input  logic              pulse_valid,
  input  logic              cmd_start,
  input  logic              cmd_pause,
  input  logic              cmd_clear,
  input  logic [CNT_W-1:0]  preset_counts,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [CNT_W-1:0]  mem_wr_data,
  input  logic [CNT_W-1:0]  mem_rd_data,
  output logic              running,
  output logic              clearing,
  output logic              preset_done,
  output logic              sat_flag,
  output logic [CNT_W-1:0]  total_count,
  output logic [CNT_W-1:0]  dropped_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  // Saturating increment at the counter width
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(SAT_W'(v), CNT_W));
  endfunction

  logic [CMD_W-1:0] cmd_event;
  logic             ev_clear;
  logic             ev_pause;
  logic             ev_start;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [CNT_W-1:0]  total_nxt;
  logic [CNT_W-1:0]  dropped_nxt;
  logic              sat_nxt;
  logic              preset_done_nxt;
  logic              running_nxt;
  logic              clearing_nxt;
  logic              pause_pend;
  logic              pause_pend_nxt;
  logic              clear_pend;
  logic              clear_pend_nxt;
  logic              clear_now;
  logic              pause_now;
  logic              preset_hit;

  // Low pulse-height bits below the channel field are intentionally dropped
  logic unused_height;
  assign unused_height = ^pulse_height;

  mca_cmd_sync u_cmd_sync (
    .clk       (CLOCK_65),
    .rst_n     (rst_n),
    .cmd_start (cmd_start),
    .cmd_pause (cmd_pause),
    .cmd_clear (cmd_clear),
    .cmd_event (cmd_event)
  );

  assign ev_clear = cmd_event[CMD_CLEAR];
  assign ev_pause = cmd_event[CMD_PAUSE];
  assign ev_start = cmd_event[CMD_START];

  // Next-state and datapath decode
  always_comb begin
    state_nxt       = state;
    addr_nxt        = mem_addr;
    total_nxt       = total_count;
    dropped_nxt     = dropped_count;
    sat_nxt         = sat_flag;
    preset_done_nxt = preset_done;
    pause_pend_nxt  = pause_pend;
    clear_pend_nxt  = clear_pend;
    clear_now       = 1'b0;
    pause_now       = 1'b0;
    preset_hit      = 1'b0;

    unique case (state)
      ST_PAUSE: begin
        if (ev_clear) begin
          state_nxt = ST_CLEAR;
          addr_nxt  = '0;
        end else if (ev_start) begin
          state_nxt       = ST_IDLE;
          preset_done_nxt = 1'b0;
        end else begin
          state_nxt = ST_PAUSE;
        end
      end

      ST_IDLE: begin
        // Pause beats a simultaneous pulse; that pulse is not counted anywhere
        if (ev_clear) begin
          state_nxt = ST_CLEAR;
          addr_nxt  = '0;
        end else if (ev_pause) begin
          state_nxt = ST_PAUSE;
        end else if (pulse_valid) begin
          state_nxt = ST_READ;
          addr_nxt  = pulse_height[ADC_W-1 -: ADDR_W];
        end else begin
          state_nxt = ST_IDLE;
        end
      end

      ST_READ: begin
        if (pulse_valid) begin
          dropped_nxt = cnt_inc(dropped_count);
        end else begin
          dropped_nxt = dropped_count;
        end
        if (ev_clear) begin
          clear_pend_nxt = 1'b1;
        end else if (ev_pause) begin
          pause_pend_nxt = 1'b1;
        end else begin
          clear_pend_nxt = clear_pend;
        end
        state_nxt = ST_WRITE;
      end

      ST_WRITE: begin
        if (pulse_valid) begin
          dropped_nxt = cnt_inc(dropped_count);
        end else begin
          dropped_nxt = dropped_count;
        end
        if (&mem_rd_data) begin
          sat_nxt = 1'b1;
        end else begin
          sat_nxt = sat_flag;
        end
        total_nxt  = cnt_inc(total_count);
        preset_hit = (preset_counts != '0) && (total_nxt == preset_counts);
        clear_now  = clear_pend | ev_clear;
        pause_now  = pause_pend | ev_pause;
        clear_pend_nxt = 1'b0;
        pause_pend_nxt = 1'b0;
        if (preset_hit) begin
          preset_done_nxt = 1'b1;
        end else begin
          preset_done_nxt = preset_done;
        end
        // The write in this cycle always lands before any pending command acts
        if (clear_now) begin
          state_nxt = ST_CLEAR;
          addr_nxt  = '0;
        end else if (preset_hit || pause_now) begin
          state_nxt = ST_PAUSE;
        end else begin
          state_nxt = ST_IDLE;
        end
      end

      ST_CLEAR: begin
        total_nxt   = '0;
        dropped_nxt = '0;
        sat_nxt     = 1'b0;
        if (ev_clear) begin
          addr_nxt = '0;
        end else if (mem_addr == LAST_ADDR) begin
          state_nxt = ST_PAUSE;
        end else begin
          addr_nxt = mem_addr + ADDR_W'(1);
        end
      end

      default: begin
        state_nxt = ST_PAUSE;
        addr_nxt  = '0;
      end
    endcase

    running_nxt  = (state_nxt == ST_IDLE) || (state_nxt == ST_READ) ||
                   (state_nxt == ST_WRITE);
    clearing_nxt = (state_nxt == ST_CLEAR);
  end

  // State register and registered outputs
  always_ff @(posedge CLOCK_65 or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_PAUSE;
      mem_addr      <= '0;
      total_count   <= '0;
      dropped_count <= '0;
      sat_flag      <= 1'b0;
      preset_done   <= 1'b0;
      running       <= 1'b0;
      clearing      <= 1'b0;
      pause_pend    <= 1'b0;
      clear_pend    <= 1'b0;
    end else begin
      state         <= state_nxt;
      mem_addr      <= addr_nxt;
      total_count   <= total_nxt;
      dropped_count <= dropped_nxt;
      sat_flag      <= sat_nxt;
      preset_done   <= preset_done_nxt;
      running       <= running_nxt;
      clearing      <= clearing_nxt;
      pause_pend    <= pause_pend_nxt;
      clear_pend    <= clear_pend_nxt;
    end
  end

  // RAM write strobe and data decoded from state and the read-back count
  always_comb begin
    mem_wr_en   = (state == ST_WRITE) || (state == ST_CLEAR);
    mem_wr_data = '0;
    if (state == ST_WRITE) begin
      mem_wr_data = cnt_inc(mem_rd_data);
    end else begin
      mem_wr_data = '0;
    end
  end

endmodule

// File: doc/mca_histogram.md
Name: mca_histogram

Overview:
- Parametrised multichannel-analyser histogram engine. Bins each accepted pulse height into a channel of an external single-port synchronous count RAM using read-modify-write.
- Successor to the fixed 14-bit/1024-channel spectrum builder, adding:
  - generic widths;
  - synchronous edge-detected commands;
  - saturating counts;
  - preset-count auto-stop;
  - dead-time (dropped-pulse) accounting.
- Sits between the pulse-shaping/peak-detect front end and the spectrum RAM/display readout.

Parameters:
- ADC_W, 14, pulse height width in bits.
- ADDR_W, 10, channel address width; number of channels is 2^ADDR_W. ADDR_W <= ADC_W is required.
- CNT_W, 32, per-channel count width; also the width of the total and dropped counters.

Ports:
- CLOCK_65  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pulse_height  in  ADC_W  peak amplitude; valid while pulse_valid is high.
- pulse_valid  in  1  one-cycle strobe marking a new pulse.
- cmd_start  in  1  level input; its rising edge starts acquisition.
- cmd_pause  in  1  level input; its rising edge pauses acquisition.
- cmd_clear  in  1  level input; its rising edge clears the spectrum.
- preset_counts  in  CNT_W  auto-stop total; 0 disables the preset.
- mem_addr  out  ADDR_W  RAM address.
- mem_wr_en  out  1  RAM write enable.
- mem_wr_data  out  CNT_W  RAM write data.
- mem_rd_data  in  CNT_W  RAM read data, valid 1 cycle after mem_addr.
- running  out  1  high in IDLE, READ and WRITE.
- clearing  out  1  high in CLEAR.
- preset_done  out  1  sticky; set when the preset stop fires.
- sat_flag  out  1  sticky; set when any channel saturates.
- total_count  out  CNT_W  number of pulses binned.
- dropped_count  out  CNT_W  number of pulses lost to dead time.

Behaviour:
- Reset (asynchronous):
  - state = PAUSE;
  - every output = 0;
  - command edge-detect registers = 0, so a command held high through reset does not fire.
- Commands:
  - Each command is registered; its rising edge is a one-cycle event.
  - Priority: clear > pause > start.
- States (one-hot): PAUSE, IDLE, READ, WRITE, CLEAR.
- PAUSE:
  - mem_wr_en = 0; pulses are ignored and not counted.
  - start: go to IDLE and clear preset_done.
  - clear: go to CLEAR.
- IDLE:
  - On pulse_valid, latch chan = pulse_height[ADC_W-1 -: ADDR_W], drive mem_addr = chan, go to READ.
  - A pulse and a pause edge in the same cycle: the pause wins and the pulse is discarded uncounted.
- READ (mem_rd_data becomes valid):
  - go to WRITE.
- WRITE:
  - mem_wr_en = 1 for exactly one cycle.
  - mem_wr_data = mem_rd_data + 1, except when mem_rd_data = all ones: write all ones and set sat_flag.
  - total_count increments, saturating at all ones.
  - If preset_counts != 0 and the new total_count == preset_counts: go to PAUSE and set preset_done.
  - Otherwise go to PAUSE if a pause edge was seen during READ/WRITE, else go to IDLE.
- Dead time:
  - Any pulse_valid seen in READ or WRITE increments dropped_count, saturating.
  - A pause edge during READ/WRITE is latched; the write always completes, so there are no partial updates.
- CLEAR:
  - mem_addr sweeps 0 .. 2^ADDR_W-1, one address per cycle, with mem_wr_en = 1 and mem_wr_data = 0.
  - Zeroes total_count, dropped_count and sat_flag.
  - After the last address, go to PAUSE.
  - start and pause edges are ignored. A clear edge during CLEAR restarts the sweep at address 0.
  - A clear edge from IDLE is taken immediately. A clear edge during READ/WRITE is latched and taken after the write completes.
- Timing:
  - Throughput: 1 pulse per 3 cycles.
  - Latency: pulse_valid to RAM write = 2 cycles.
  - Clear duration: 2^ADDR_W cycles.
- Outputs are registered except mem_wr_en and mem_wr_data, which may be decoded from state and registered data.

Decomposition:
- Shared package mca_pkg holds:
  - state encodings (one-hot localparams);
  - command priority constants;
  - a saturating-increment function, reused for channel data, total_count and dropped_count.
- Natural sub-module: mca_cmd_sync, the three-input edge detector and priority encoder that outputs one-hot cmd events.
- The FSM and datapath stay in mca_histogram.

Test Plan:
- Reset-release with cmd_start held high -> stays PAUSE and running = 0. Later, a start edge -> running = 1 after 1 cycle.
- Start, then pulses with heights 0x0010, 0x0010, 0x3FF0 (default params), spaced 4 cycles apart, with RAM pre-zeroed -> writes 1 and then 2 to channel 1, and 1 to channel 1023; total_count = 3.
- Pulse_valid on 3 consecutive cycles -> 1 binned, dropped_count = 2, exactly one mem_wr_en pulse.
- Preset_counts = 5, then 7 spaced pulses -> state PAUSE after the 5th write, preset_done = 1, total_count = 5, pulses 6–7 ignored.
- Channel pre-loaded with 0xFFFFFFFF, then a pulse to that channel -> 0xFFFFFFFF written back, sat_flag = 1.
- Clear edge during WRITE -> write completes, then 1024 zero writes at addresses 0..1023, counters = 0, ends in PAUSE. A second clear edge mid-sweep -> sweep restarts at address 0.
